// File: rtl/set_key_conditioner_pkg.sv
// Shared types and default timing for the alarm-clock set-key front end.
// This package holds the key FSM state encoding and the counter-width helper.
package set_key_conditioner_pkg;

  typedef enum logic [1:0] {
    KS_IDLE  = 2'd0,
    KS_DELAY = 2'd1,
    KS_RATE  = 2'd2
  } key_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_REPEAT_DELAY    = 16;
  localparam int DEF_REPEAT_RATE     = 4;

  // Width of a counter that must hold the values 0..n-1, never less than 1 bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/set_key_conditioner_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw input.
// db only follows the synchronised input after DEBOUNCE_CYCLES consecutive disagreeing samples.
module key_debounce
  import set_key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic db
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          q1_q, q2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (q2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = q2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q1_q  <= 1'b0;
      q2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      q1_q  <= raw;
      q2_q  <= q1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/set_key_conditioner.sv
// Set-button conditioner for the alarm-clock Timer: debounce every key, turn each
// hours/mins press into one pulse plus auto-repeat, and pass the switch level through.
module set_key_conditioner
  import set_key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_hours_raw,
  input  logic       key_mins_raw,
  input  logic       key_tog_raw,
  output logic       hours_set,
  output logic       mins_set,
  output logic       Toggle_switch,
  output key_state_e dbg_hours_state_o,
  output key_state_e dbg_mins_state_o
);

  localparam int RW = cnt_w(REPEAT_DELAY);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [1:0] key_db;
  logic [1:0] key_set;
  logic       tog_db;
  logic       tog_q;
  key_state_e key_state [2];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hours (
    .clk(clk), .reset_n(reset_n), .raw(key_hours_raw), .db(key_db[0])
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mins (
    .clk(clk), .reset_n(reset_n), .raw(key_mins_raw), .db(key_db[1])
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_tog (
    .clk(clk), .reset_n(reset_n), .raw(key_tog_raw), .db(tog_db)
  );

  // Channel 0 is hours, channel 1 is minutes; the two never interact.
  for (genvar g = 0; g < 2; g++) begin : g_key
    key_state_e    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          pulse_q, pulse_d;
    logic          set_q;

    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      pulse_d = 1'b0;
      case (state_q)
        KS_IDLE: begin
          if (key_db[g]) begin
            pulse_d = 1'b1;
            state_d = KS_DELAY;
            rcnt_d  = '0;
          end
        end
        KS_DELAY: begin
          if (!key_db[g]) begin
            state_d = KS_IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == DELAY_LAST) begin
            pulse_d = 1'b1;
            state_d = KS_RATE;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        KS_RATE: begin
          if (!key_db[g]) begin
            state_d = KS_IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == RATE_LAST) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        default: begin
          state_d = KS_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end

    // set_q is a retiming stage so the Timer sees a clean flop output.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= KS_IDLE;
        rcnt_q  <= '0;
        pulse_q <= 1'b0;
        set_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
        pulse_q <= pulse_d;
        set_q   <= pulse_q;
      end
    end

    assign key_set[g]   = set_q;
    assign key_state[g] = state_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tog_q <= 1'b0;
    else          tog_q <= tog_db;
  end

  assign hours_set         = key_set[0];
  assign mins_set          = key_set[1];
  assign Toggle_switch     = tog_q;
  assign dbg_hours_state_o = key_state[0];
  assign dbg_mins_state_o  = key_state[1];

endmodule
